pipe_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RV32I core. It sits beside the ID stage and takes the decoded fields for the instruction in ID. It keeps its own shadow scoreboard of the instructions in EX and MEM. From these it drives the stall, flush and forwarding controls of every pipeline register and runs the data-memory wait handshake, with a watchdog that turns a hung memory access into a sticky error.

---
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl.sv | 98 +++++++++
 tb/tb_pipe_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: decode fields in, hazard/forward/memory-wait controls out
interface pipe_ctrl_if #(parameter int CNT_WIDTH = 32);
  logic                 id_valid;
  logic [4:0]           id_rs1;
  logic [4:0]           id_rs2;
  logic                 id_rs1_need;
  logic                 id_rs2_need;
  logic [4:0]           id_rd;
  logic                 id_reg_we;
  logic                 id_mem_we;
  logic [1:0]           id_wb_ctr;
  logic                 ex_redirect;
  logic                 dmem_ready;
  logic                 dmem_req;
  logic                 pc_stall;
  logic                 ifid_stall;
  logic                 idex_stall;
  logic                 exmem_stall;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 memwb_flush;
  logic [1:0]           fwd_a;
  logic [1:0]           fwd_b;
  logic                 bus_err;
  logic [CNT_WIDTH-1:0] lu_cnt;
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_need, id_rs2_need, id_rd, id_reg_we,
           id_mem_we, id_wb_ctr, ex_redirect, dmem_ready,
    input  dmem_req, pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
           idex_flush, memwb_flush, fwd_a, fwd_b, bus_err, lu_cnt
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_need, id_rs2_need, id_rd, id_reg_we,
           id_mem_we, id_wb_ctr, ex_redirect, dmem_ready,
    output dmem_req, pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
           idex_flush, memwb_flush, fwd_a, fwd_b, bus_err, lu_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage hazard controller with EX/MEM shadow scoreboard and dmem watchdog
module pipe_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t               r_state;
  logic [WW-1:0]        r_wcnt;
  logic                 r_ex_v, r_ex_we, r_ex_ld, r_ex_mem;
  logic [4:0]           r_ex_rd;
  logic                 r_mem_v, r_mem_we, r_mem_mem;
  logic [4:0]           r_mem_rd;
  logic [1:0]           r_fwd_a, r_fwd_b;
  logic                 r_bus_err;
  logic [CNT_WIDTH-1:0] r_lu_cnt;
  logic                 w_req, w_freeze, w_redir, w_lu, w_load_ex;
  logic [1:0]           w_fa, w_fb;
  assign w_req    = r_mem_v && r_mem_mem;
  assign w_freeze = (w_req && !bus.dmem_ready) || r_state == S_ERR;
  // a redirect can only come from a real instruction in EX, so bubbles and reset ignore it
  assign w_redir  = !w_freeze && bus.ex_redirect && r_ex_v;
  assign w_lu     = !w_freeze && !w_redir && bus.id_valid && r_ex_v && r_ex_ld && r_ex_we &&
                    ((bus.id_rs1_need && bus.id_rs1 == r_ex_rd) ||
                     (bus.id_rs2_need && bus.id_rs2 == r_ex_rd));
  assign w_load_ex = bus.id_valid && !w_redir && !w_lu;
  assign w_fa = (!bus.id_rs1_need || bus.id_rs1 == 5'd0) ? 2'b00 :
                (r_ex_v && r_ex_we && r_ex_rd == bus.id_rs1) ? 2'b01 :
                (r_mem_v && r_mem_we && r_mem_rd == bus.id_rs1) ? 2'b10 : 2'b00;
  assign w_fb = (!bus.id_rs2_need || bus.id_rs2 == 5'd0) ? 2'b00 :
                (r_ex_v && r_ex_we && r_ex_rd == bus.id_rs2) ? 2'b01 :
                (r_mem_v && r_mem_we && r_mem_rd == bus.id_rs2) ? 2'b10 : 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_wcnt    <= '0;
      r_ex_v    <= 1'b0;
      r_ex_we   <= 1'b0;
      r_ex_ld   <= 1'b0;
      r_ex_mem  <= 1'b0;
      r_ex_rd   <= '0;
      r_mem_v   <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_mem <= 1'b0;
      r_mem_rd  <= '0;
      r_fwd_a   <= 2'b00;
      r_fwd_b   <= 2'b00;
      r_bus_err <= 1'b0;
      r_lu_cnt  <= '0;
    end else begin
      if (!w_freeze) begin
        r_mem_v   <= r_ex_v;
        r_mem_we  <= r_ex_we;
        r_mem_mem <= r_ex_mem;
        r_mem_rd  <= r_ex_rd;
        r_ex_v    <= w_load_ex;
        r_ex_rd   <= bus.id_rd;
        r_ex_we   <= bus.id_reg_we && bus.id_rd != 5'd0;
        r_ex_ld   <= bus.id_wb_ctr == 2'b11;
        r_ex_mem  <= bus.id_wb_ctr == 2'b11 || bus.id_mem_we;
        r_fwd_a   <= w_load_ex ? w_fa : 2'b00;
        r_fwd_b   <= w_load_ex ? w_fb : 2'b00;
        if (w_lu) r_lu_cnt <= r_lu_cnt + 1'b1;
      end
      case (r_state)
        S_RUN: if (w_req && !bus.dmem_ready) begin
          r_state <= S_WAIT;
          r_wcnt  <= '0;
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + 1'b1;
          if (bus.dmem_ready) r_state <= S_RUN;
          else if (r_wcnt == WW'(TIMEOUT - 1)) begin
            r_state   <= S_ERR;
            r_bus_err <= 1'b1;
          end
        end
        default: r_state <= S_ERR;
      endcase
    end
  end
  assign bus.dmem_req    = w_req;
  assign bus.pc_stall    = w_freeze || w_lu;
  assign bus.ifid_stall  = w_freeze || w_lu;
  assign bus.idex_stall  = w_freeze;
  assign bus.exmem_stall = w_freeze;
  assign bus.ifid_flush  = w_redir;
  assign bus.idex_flush  = w_redir || w_lu;
  assign bus.memwb_flush = w_freeze;
  assign bus.fwd_a       = r_fwd_a;
  assign bus.fwd_b       = r_fwd_b;
  assign bus.bus_err     = r_bus_err;
  assign bus.lu_cnt      = r_lu_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scenario tasks with a queue of expected EX forward selects
module tb_pipe_ctrl;
  localparam int TO = 4;
  localparam logic [7:0] IDLE = 8'h00, REQ = 8'h80, FRZ = 8'hF9, LU = 8'h62, RDR = 8'h06;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipe_ctrl_if bus ();
  pipe_ctrl #(.TIMEOUT(TO), .CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  logic [3:0]  q[$];
  logic [3:0]  e;
  logic [31:0] exp_lu = 0;
  function automatic logic [7:0] ctl();
    return {bus.dmem_req, bus.pc_stall, bus.ifid_stall, bus.idex_stall, bus.exmem_stall,
            bus.ifid_flush, bus.idex_flush, bus.memwb_flush};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic id_set(input logic v, input logic [4:0] rs1, input logic n1, input logic [4:0] rs2,
                        input logic n2, input logic [4:0] rd, input logic we, input logic mwe,
                        input logic [1:0] wb);
    bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs1_need = n1; bus.id_rs2 = rs2;
    bus.id_rs2_need = n2; bus.id_rd = rd; bus.id_reg_we = we; bus.id_mem_we = mwe; bus.id_wb_ctr = wb;
  endtask
  task automatic id_nop();
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00);
  endtask
  task automatic test_reset();
    rst = 1'b1; id_nop(); bus.ex_redirect = 1'b0; bus.dmem_ready = 1'b1;
    tick(); tick(); rst = 1'b0; #2;
    n_vec++; if (ctl() !== IDLE) begin n_err++; $display("FAIL rst_ctl got %h exp %h", ctl(), IDLE); end
    n_vec++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0) begin n_err++; $display("FAIL rst_fwd got %h exp 0", {bus.fwd_a, bus.fwd_b}); end
    n_vec++; if (bus.bus_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b exp 0", bus.bus_err); end
    n_vec++; if (bus.lu_cnt !== exp_lu) begin n_err++; $display("FAIL rst_lucnt got %0d exp %0d", bus.lu_cnt, exp_lu); end
  endtask
  task automatic test_load_use();
    id_set(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 2'b11); #2;
    n_vec++; if (ctl() !== IDLE) begin n_err++; $display("FAIL lu_issue got %h exp %h", ctl(), IDLE); end
    tick();
    id_set(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 2'b00); #2;
    n_vec++; if (ctl() !== LU) begin n_err++; $display("FAIL lu_stall got %h exp %h", ctl(), LU); end
    tick(); exp_lu++; #2;
    n_vec++; if (ctl() !== REQ) begin n_err++; $display("FAIL lu_release got %h exp %h", ctl(), REQ); end
    n_vec++; if (bus.lu_cnt !== exp_lu) begin n_err++; $display("FAIL lu_cnt got %0d exp %0d", bus.lu_cnt, exp_lu); end
    q.push_back({2'b10, 2'b00});
    tick(); id_nop(); #2;
    e = q.pop_front();
    n_vec++; if ({bus.fwd_a, bus.fwd_b} !== e) begin n_err++; $display("FAIL lu_fwd got %h exp %h", {bus.fwd_a, bus.fwd_b}, e); end
    tick(); tick();
  endtask
  task automatic test_forward();
    logic [4:0] prd[4] = '{5'd5, 5'd5, 5'd0, 5'd5};
    logic [4:0] grd[4] = '{5'd0, 5'd9, 5'd0, 5'd5};
    logic       gap[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0] rs2[4] = '{5'd5, 5'd5, 5'd0, 5'd5};
    logic [1:0] fb[4]  = '{2'b01, 2'b10, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) begin
      id_set(1, 5'd1, 1, 5'd0, 0, prd[i], 1, 0, 2'b00); tick();
      if (gap[i]) begin id_set(1, 5'd1, 1, 5'd0, 0, grd[i], 1, 0, 2'b00); tick(); end
      id_set(1, 5'd7, 1, rs2[i], 1, 5'd6, 1, 0, 2'b00);
      q.push_back({2'b00, fb[i]}); #2;
      n_vec++; if (ctl() !== IDLE) begin n_err++; $display("FAIL fwd_nostall[%0d] got %h exp %h", i, ctl(), IDLE); end
      tick(); id_nop(); #2;
      e = q.pop_front();
      n_vec++; if ({bus.fwd_a, bus.fwd_b} !== e) begin n_err++; $display("FAIL fwd_sel[%0d] got %h exp %h", i, {bus.fwd_a, bus.fwd_b}, e); end
      tick(); tick();
    end
  endtask
  task automatic test_redirect();
    id_set(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 2'b11); tick();
    id_set(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 2'b00); bus.ex_redirect = 1'b1; #2;
    n_vec++; if (ctl() !== RDR) begin n_err++; $display("FAIL redir_ctl got %h exp %h", ctl(), RDR); end
    tick(); bus.ex_redirect = 1'b0; #2;
    n_vec++; if (ctl() !== REQ) begin n_err++; $display("FAIL redir_bubble got %h exp %h", ctl(), REQ); end
    n_vec++; if (bus.lu_cnt !== exp_lu) begin n_err++; $display("FAIL redir_lucnt got %0d exp %0d", bus.lu_cnt, exp_lu); end
    q.push_back({2'b10, 2'b00});
    tick(); id_nop(); #2;
    e = q.pop_front();
    n_vec++; if ({bus.fwd_a, bus.fwd_b} !== e) begin n_err++; $display("FAIL redir_fwd got %h exp %h", {bus.fwd_a, bus.fwd_b}, e); end
    tick(); tick();
  endtask
  task automatic test_mem_wait();
    id_set(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 0, 2'b00); tick();
    id_set(1, 5'd1, 1, 5'd3, 1, 5'd0, 0, 1, 2'b00); q.push_back({2'b00, 2'b01}); tick();
    id_set(1, 5'd3, 1, 5'd0, 0, 5'd8, 1, 0, 2'b00); #2;
    e = q.pop_front();
    n_vec++; if ({bus.fwd_a, bus.fwd_b} !== e) begin n_err++; $display("FAIL sw_fwd got %h exp %h", {bus.fwd_a, bus.fwd_b}, e); end
    tick();
    id_set(1, 5'd8, 1, 5'd0, 0, 5'd10, 1, 0, 2'b00); bus.dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_vec++; if (ctl() !== FRZ) begin n_err++; $display("FAIL wait_frz[%0d] got %h exp %h", k, ctl(), FRZ); end
      n_vec++; if ({bus.fwd_a, bus.fwd_b} !== 4'b1000) begin n_err++; $display("FAIL wait_fwd[%0d] got %h exp 8", k, {bus.fwd_a, bus.fwd_b}); end
      tick();
    end
    bus.dmem_ready = 1'b1; #2;
    n_vec++; if (ctl() !== REQ) begin n_err++; $display("FAIL wait_release got %h exp %h", ctl(), REQ); end
    q.push_back({2'b01, 2'b00});
    tick(); id_nop(); #2;
    e = q.pop_front();
    n_vec++; if ({bus.fwd_a, bus.fwd_b} !== e) begin n_err++; $display("FAIL wait_advance got %h exp %h", {bus.fwd_a, bus.fwd_b}, e); end
    n_vec++; if (ctl() !== IDLE) begin n_err++; $display("FAIL wait_run got %h exp %h", ctl(), IDLE); end
    tick(); tick();
  endtask
  task automatic test_timeout();
    int n = 0;
    id_set(1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 0, 2'b11); tick();
    id_nop(); tick();
    bus.dmem_ready = 1'b0; #2;
    n_vec++; if (ctl() !== FRZ || bus.bus_err !== 1'b0) begin n_err++; $display("FAIL to_first got %h/%b exp %h/0", ctl(), bus.bus_err, FRZ); end
    while (bus.bus_err !== 1'b1 && n < 20) begin tick(); n++; end
    n_vec++; if (n !== TO + 1) begin n_err++; $display("FAIL to_cycles got %0d exp %0d", n, TO + 1); end
    bus.dmem_ready = 1'b1; #2;
    n_vec++; if (ctl() !== FRZ) begin n_err++; $display("FAIL err_hold got %h exp %h", ctl(), FRZ); end
    repeat (3) tick();
    n_vec++; if (ctl() !== FRZ || bus.bus_err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %h/%b exp %h/1", ctl(), bus.bus_err, FRZ); end
    rst = 1'b1; tick(); rst = 1'b0; exp_lu = 0; #2;
    n_vec++; if (ctl() !== IDLE || bus.bus_err !== 1'b0) begin n_err++; $display("FAIL err_rst got %h/%b exp %h/0", ctl(), bus.bus_err, IDLE); end
    n_vec++; if (bus.lu_cnt !== exp_lu) begin n_err++; $display("FAIL err_rst_lucnt got %0d exp %0d", bus.lu_cnt, exp_lu); end
  endtask
  task automatic test_reset_mid_wait();
    id_set(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 1, 2'b00); tick();
    id_set(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 2'b00); tick();
    id_nop(); bus.dmem_ready = 1'b0; tick();
    id_set(1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 2'b00); bus.ex_redirect = 1'b1; #2;
    n_vec++; if (ctl() !== FRZ) begin n_err++; $display("FAIL mw_frz got %h exp %h", ctl(), FRZ); end
    rst = 1'b1; tick(); rst = 1'b0; #2;
    n_vec++; if (ctl() !== IDLE) begin n_err++; $display("FAIL mw_rst_ctl got %h exp %h", ctl(), IDLE); end
    n_vec++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0 || bus.bus_err !== 1'b0) begin n_err++; $display("FAIL mw_rst_regs got %h/%b exp 0/0", {bus.fwd_a, bus.fwd_b}, bus.bus_err); end
    bus.ex_redirect = 1'b0; bus.dmem_ready = 1'b1;
    q.push_back(4'b0000);
    tick(); id_nop(); #2;
    e = q.pop_front();
    n_vec++; if ({bus.fwd_a, bus.fwd_b} !== e) begin n_err++; $display("FAIL mw_fwd got %h exp %h", {bus.fwd_a, bus.fwd_b}, e); end
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
